// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR sequencer.
package sar_pkg;

  localparam int unsigned MaxCh   = 32;
  localparam int unsigned MaxBits = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSamp,
    StConv,
    StAcc,
    StNext
  } sar_state_e;

  // 100...0 for an nbits-wide code; callers truncate to their width.
  function automatic logic [MaxBits-1:0] mid_scale(input int unsigned nbits);
    return MaxBits'(1) << (nbits - 1);
  endfunction

  // Lowest set bit of mask at or above position from, or -1 if none.
  function automatic int next_set_bit(input logic [MaxCh-1:0] mask, input int from);
    int found;
    found = -1;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) found = i;
    end
    return found;
  endfunction

endpackage

// File: rtl/sar_bitsearch.sv
// Sample phase plus MSB-first binary-search register driving the CDAC code pair.
module sar_bitsearch
  import sar_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NSAMP = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic [NBITS-1:0] resultp_o,
  output logic [NBITS-1:0] resultn_o,
  output logic             done_o
);

  localparam int unsigned SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [NBITS-1:0] Mid = NBITS'(mid_scale(NBITS));

  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] trial_q, trial_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             samp_q, samp_d;
  logic             conv_q, conv_d;

  always_comb begin
    code_d  = code_q;
    trial_d = trial_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    conv_d  = conv_q;
    if (start_i) begin
      code_d  = Mid;
      trial_d = Mid;
      cnt_d   = '0;
      samp_d  = 1'b1;
      conv_d  = 1'b0;
    end else if (samp_q) begin
      if (cnt_q == SW'(NSAMP - 1)) begin
        samp_d = 1'b0;
        conv_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + SW'(1);
      end
    end else if (conv_q) begin
      // Resolve the bit under trial, then raise the next lower one.
      code_d  = (cmp_i ? code_q : (code_q & ~trial_q)) | (trial_q >> 1);
      trial_d = trial_q >> 1;
      if (trial_q[0]) conv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q  <= '0;
      trial_q <= '0;
      cnt_q   <= '0;
      samp_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      code_q  <= code_d;
      trial_q <= trial_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      conv_q  <= conv_d;
    end
  end

  assign resultp_o = code_q;
  assign resultn_o = ~code_q;
  assign done_o    = conv_q & trial_q[0];

endmodule

// File: rtl/sar_seq_logic.sv
// Multi-channel SAR scan sequencer with valid/ready result port.
// Define SAR_OSR_EN to enable 2^OSR oversampling accumulation per channel.
module sar_seq_logic
  import sar_pkg::*;
#(
  parameter  int unsigned NBITS   = 8,
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned NSAMP   = 2,
  parameter  int unsigned OSR_MAX = 3,
  localparam int unsigned CHW     = $clog2(NCH),
  localparam int unsigned OW      = $clog2(OSR_MAX + 1),
  localparam int unsigned RW      = NBITS + OSR_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  input  logic             CONT,
  input  logic [NCH-1:0]   CH_MASK,
  input  logic [OW-1:0]    OSR,
  input  logic             CMP,
  output logic             SAMPLE,
  output logic [CHW-1:0]   CHSEL,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             BUSY,
  output logic             VALID,
  input  logic             READY,
  output logic [RW-1:0]    RESULT,
  output logic [CHW-1:0]   RESULT_CH,
  output logic             OVERRUN
);

  localparam int unsigned SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  sar_state_e       state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [CHW-1:0]   chsel_q, chsel_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [RW-1:0]    result_q, result_d;
  logic [CHW-1:0]   result_ch_q, result_ch_d;
  logic [NBITS-1:0] code;
  logic             bs_start, bs_done;
  int               idle_ch, next_ch, wrap_ch;

`ifdef SAR_OSR_EN
  localparam int unsigned NW = OSR_MAX + 1;
  logic [OW-1:0]    osr_q, osr_d;
  logic [NW-1:0]    nconv_q, nconv_d;
  logic [RW-1:0]    acc_q, acc_d;
`else
  logic             unused_osr;
  assign unused_osr = ^OSR;
`endif

  assign idle_ch = next_set_bit(MaxCh'(CH_MASK), 0);
  assign next_ch = next_set_bit(MaxCh'(mask_q), int'(chsel_q) + 1);
  assign wrap_ch = next_set_bit(MaxCh'(mask_q), 0);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    chsel_d     = chsel_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
`ifdef SAR_OSR_EN
    osr_d       = osr_q;
    nconv_d     = nconv_q;
    acc_d       = acc_q;
`endif
    if (valid_q && READY) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (GO && (|CH_MASK)) begin
          state_d   = StSamp;
          mask_d    = CH_MASK;
          chsel_d   = CHW'(idle_ch);
          cnt_d     = '0;
          overrun_d = 1'b0;
`ifdef SAR_OSR_EN
          osr_d     = (OSR > OW'(OSR_MAX)) ? OW'(OSR_MAX) : OSR;
`endif
        end
      end
      StSamp: begin
        if (cnt_q == SW'(NSAMP - 1)) begin
          state_d = StConv;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      StConv: begin
        if (bs_done) state_d = StAcc;
      end
      StAcc: begin
`ifdef SAR_OSR_EN
        acc_d = acc_q + RW'(code);
        if (nconv_q == ((NW'(1) << osr_q) - NW'(1))) begin
          state_d = StNext;
        end else begin
          nconv_d = nconv_q + NW'(1);
          state_d = StSamp;
        end
`else
        state_d = StNext;
`endif
      end
      StNext: begin
        valid_d     = 1'b1;
        result_ch_d = chsel_q;
        if (valid_q && !READY) overrun_d = 1'b1;
`ifdef SAR_OSR_EN
        result_d    = acc_q;
        acc_d       = '0;
        nconv_d     = '0;
`else
        result_d    = RW'(code);
`endif
        if (next_ch >= 0) begin
          chsel_d = CHW'(next_ch);
          state_d = StSamp;
        end else if (CONT) begin
          chsel_d = CHW'(wrap_ch);
          state_d = StSamp;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every entry into SAMP restarts the search register with the mid-scale code.
  assign bs_start = (state_d == StSamp) && (state_q != StSamp);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      chsel_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
`ifdef SAR_OSR_EN
      osr_q       <= '0;
      nconv_q     <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      chsel_q     <= chsel_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
`ifdef SAR_OSR_EN
      osr_q       <= osr_d;
      nconv_q     <= nconv_d;
      acc_q       <= acc_d;
`endif
    end
  end

  sar_bitsearch #(
    .NBITS (NBITS),
    .NSAMP (NSAMP)
  ) u_bitsearch (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .start_i   (bs_start),
    .cmp_i     (CMP),
    .resultp_o (code),
    .resultn_o (RESULTN),
    .done_o    (bs_done)
  );

  assign RESULTP   = code;
  assign SAMPLE    = (state_q == StSamp);
  assign BUSY      = (state_q != StIdle);
  assign CHSEL     = chsel_q;
  assign VALID     = valid_q;
  assign RESULT    = result_q;
  assign RESULT_CH = result_ch_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: doc/sar_seq_logic.md
# sar_seq_logic

Multi-channel successor to the single-channel SAR controller. Sequences an external analog mux across up to NCH inputs and runs one NBITS-bit binary-search conversion per sample. Optionally accumulates 2^OSR conversions per channel (oversampling). Sits in SARADC in place of the single-channel digital block: it drives the CDAC code pair and SAMPLE, and presents channel-tagged results over a valid/ready handshake.

## Interface
Parameters:
- NBITS, 8, conversion resolution.
- NCH, 4, channel count (≥2); CHW = $clog2(NCH).
- NSAMP, 2, sample-phase length in cycles (≥1).
- OSR_MAX, 3, max log2 oversampling; RW = NBITS+OSR_MAX.

Ports:
- CLK  in  1  clock (buffered CLK from the analog top).
- RST  in  1  asynchronous, active-low reset.
- GO  in  1  start a scan; level-sampled in IDLE only.
- CONT  in  1  1 = restart the scan automatically after the last channel.
- CH_MASK  in  NCH  enabled channels; sampled at scan start.
- OSR  in  $clog2(OSR_MAX+1)  log2 conversions per channel; sampled at scan start; clamped to OSR_MAX.
- CMP  in  1  comparator output: 1 = input above DAC code.
- SAMPLE  out  1  S&H enable.
- CHSEL  out  CHW  analog mux select.
- RESULTP / RESULTN  out  NBITS each  CDAC code; RESULTN = ~RESULTP.
- BUSY  out  1  scan in progress.
- VALID  out  1  RESULT/RESULT_CH hold a result.
- READY  in  1  consumer accepts the result.
- RESULT  out  RW  accumulated sum, zero-extended, not shifted.
- RESULT_CH  out  CHW  channel of RESULT.
- OVERRUN  out  1  sticky; set when a result is lost.

## Operation
FSM states: IDLE, SAMP, CONV, ACC, NEXT.
- IDLE: enter SAMP when GO=1 and CH_MASK≠0. Latch mask and OSR, select the lowest set bit of the mask as CHSEL. GO with mask=0 is ignored.
- SAMP: SAMPLE=1 for NSAMP cycles. RESULTP = 1000…0 (mid-scale), then → CONV.
- CONV: NBITS cycles, MSB first.
  - In trial cycle k, bit NBITS-1-k = 1 is on RESULTP.
  - At the end of the cycle, CMP=1 keeps the bit and CMP=0 clears it.
  - The next lower bit is set for the next trial.
- ACC: add the final code to the accumulator.
  - Conversion count < 2^OSR → SAMP (same channel).
  - Otherwise → NEXT.
- NEXT: load the output register and clear the accumulator.
  - CHSEL advances to the next set mask bit above the current one → SAMP.
  - If none remain: CONT=1 → lowest set bit, SAMP; CONT=0 → IDLE.
- Output register: load sets VALID. VALID drops the cycle after VALID&READY.
- Overrun: NEXT while VALID=1 and READY=0 overwrites the register and sets OVERRUN. OVERRUN is cleared only by a GO accepted in IDLE.
- BUSY=1 in every state except IDLE.
- GO, CH_MASK, OSR and CONT changes during a scan have no effect until the next scan start, except that CONT is read at each wrap.

## Timing
- Reset values:
  - State IDLE, accumulator 0.
  - SAMPLE=0, CHSEL=0, RESULTP=0, RESULTN=all ones, BUSY=0.
  - VALID=0, RESULT=0, RESULT_CH=0, OVERRUN=0.
- Reset mid-conversion aborts immediately to these values; the partial result is discarded.
- One conversion takes NSAMP+NBITS+1 cycles (SAMP+CONV+ACC).
- One channel takes 2^OSR·(NSAMP+NBITS+1)+1 cycles.
- VALID rises the cycle after NEXT.
- The accumulator cannot overflow: max sum (2^NBITS−1)·2^OSR_MAX fits in RW.
- NCH not a power of two: CHSEL never exceeds NCH−1; mask bits above NCH do not exist.
- READY=1 with VALID=1 in the same cycle as a new load: the new result is kept, VALID stays 1, no overrun.

## Configuration
- SAR_OSR_EN defined: oversampling accumulation as described.
- SAR_OSR_EN undefined:
  - OSR is ignored and treated as 0; one conversion per channel.
  - The accumulator is removed; RESULT = {OSR_MAX'b0, code}.
  - RW and port widths are unchanged.

## Structure
- Package sar_pkg: FSM state enum, mid-scale constant helper, and a function for the next set bit at or above a position.
- One sub-module, sar_bitsearch: the SAMP/CONV binary-search register. Its interface is start, CMP, RESULTP/RESULTN and done.
- Channel sequencing, accumulation and the handshake stay in sar_seq_logic.

## Test plan
- NBITS=8, CMP model with threshold code 0xA5, CH_MASK=4'b0001, OSR=0, GO pulse → RESULT=0x0A5, RESULT_CH=0, VALID after 2+8+1+1+1 cycles.
- Thresholds ch0..3 = 0x10,0x80,0xFF,0x00, mask 4'b0101, READY=1 → two results: (ch0,0x010) then (ch2,0x0FF). CHSEL never equals 1 or 3; BUSY falls after the scan.
- OSR=2, threshold 0xA5 on ch1, mask 4'b0010 → RESULT=0x294 (0x294 with SAR_OSR_EN; 0x0A5 without).
- READY=0 held, mask 4'b1111, CONT=0 → OVERRUN=1 after the second result and RESULT_CH=3 at end. A following GO clears OVERRUN.
- RST low in the 4th CONV cycle → all outputs at reset values the same cycle; a GO after release gives a correct full conversion.
- CONT=1, mask 4'b1000 → repeated results on ch3. GO with CH_MASK=0 in IDLE → BUSY stays 0.
